// File: rtl/fifo_arb_pkg.sv
// Shared constants and helpers for the round-robin FIFO write arbiter
// and its priority picker.
package fifo_arb_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int STALL_CNT_W    = 16;

    // Width able to hold every occupancy value 0..depth inclusive
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arb_chk.sv
// Protocol checker for the arbiter: a pop must never be reported while the
// tracked occupancy is zero.
module fifo_wr_arb_chk #(
    parameter int LVL_W = 4
) (
    input logic             clk,
    input logic             rst,
    input logic             rd_pop_i,
    input logic [LVL_W-1:0] level_o
);

    pop_nonempty_a: assert property (@(posedge clk) disable iff (rst)
        !(rd_pop_i && (level_o == '0)));

endmodule

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin pick: first set mask bit at or after ptr_i,
// wrapping at NUM_REQ-1, returned one-hot together with a valid flag.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int PTR_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] mask_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] onehot_o,
    output logic               valid_o
);

    localparam logic [PTR_W:0] NREQ_W = (PTR_W+1)'(NUM_REQ);

    logic [PTR_W:0]   sum_s;
    logic [PTR_W-1:0] pos_s;
    logic             hit_s;

    // Walk the mask starting from the pointer and keep the first hit
    always_comb begin
        onehot_o = '0;
        valid_o  = 1'b0;
        sum_s    = '0;
        pos_s    = '0;
        hit_s    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum_s           = {1'b0, ptr_i} + (PTR_W+1)'(i);
            sum_s           = (sum_s >= NREQ_W) ? (sum_s - NREQ_W) : sum_s;
            pos_s           = sum_s[PTR_W-1:0];
            hit_s           = !valid_o && mask_i[pos_s];
            onehot_o[pos_s] = onehot_o[pos_s] | hit_s;
            valid_o         = valid_o | hit_s;
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter sharing one fifo_sync among NUM_REQ producers.
// Optional stall counter output enabled by defining FIFO_ARB_STATS_EN.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    input  logic                          rd_pop_i,
    input  logic                          fifo_full_i,
    output logic                          fifo_cs_o,
    output logic                          fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]         fifo_data_o,
    output logic [lvl_w(FIFO_DEPTH)-1:0]  level_o
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [STALL_CNT_W-1:0]        stall_cnt_o
`endif
);

    localparam int               PTR_W    = $clog2(NUM_REQ);
    localparam int               LVL_W    = lvl_w(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    logic [NUM_REQ-1:0]    gnt_r;
    logic                  wr_en_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic [LVL_W-1:0]      level_r;
    logic [PTR_W-1:0]      ptr_r;

    logic [NUM_REQ-1:0]    elig_s;
    logic [NUM_REQ-1:0]    win_s;
    logic                  win_vld_s;
    logic [PTR_W-1:0]      win_idx_s;
    logic [PTR_W-1:0]      ptr_nxt_s;
    logic [DATA_WIDTH-1:0] win_data_s;
    logic                  issue_s;
    logic [LVL_W-1:0]      level_nxt_s;

    // A producer just granted is still presenting its old word; mask it
    assign elig_s = req_i & ~gnt_r;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .mask_i   (elig_s),
        .ptr_i    (ptr_r),
        .onehot_o (win_s),
        .valid_o  (win_vld_s)
    );

    // Encode the winner index and steer its payload
    always_comb begin
        win_idx_s  = '0;
        win_data_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            win_idx_s  = win_idx_s | (PTR_W'(k) & {PTR_W{win_s[k]}});
            win_data_s = win_data_s
                       | (data_i[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{win_s[k]}});
        end
    end

    assign ptr_nxt_s = (win_idx_s == PTR_LAST) ? '0 : (win_idx_s + PTR_W'(1));

    // The FIFO's own full flag lags a cycle, so the local level is the primary guard
    assign issue_s = en_i & win_vld_s & (level_r < LVL_FULL) & ~fifo_full_i;

    // Occupancy update; a pop at zero is a protocol error and is ignored
    always_comb begin
        level_nxt_s = level_r;
        case ({issue_s, rd_pop_i})
            2'b10:   level_nxt_s = level_r + LVL_W'(1);
            2'b01:   level_nxt_s = (level_r != '0) ? (level_r - LVL_W'(1)) : level_r;
            default: level_nxt_s = level_r;
        endcase
    end

    // Grant, write strobe, payload, pointer and level registers
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_r   <= '0;
            wr_en_r <= 1'b0;
            data_r  <= '0;
            level_r <= '0;
            ptr_r   <= '0;
        end else begin
            level_r <= level_nxt_s;
            if (issue_s) begin
                gnt_r   <= win_s;
                wr_en_r <= 1'b1;
                data_r  <= win_data_s;
                ptr_r   <= ptr_nxt_s;
            end else begin
                gnt_r   <= '0;
                wr_en_r <= 1'b0;
            end
        end
    end

    assign gnt_o        = gnt_r;
    assign fifo_cs_o    = en_i;
    assign fifo_wr_en_o = wr_en_r;
    assign fifo_data_o  = data_r;
    assign level_o      = level_r;

`ifdef FIFO_ARB_STATS_EN
    logic [STALL_CNT_W-1:0] stall_cnt_r;
    logic                   stall_s;

    assign stall_s = en_i & win_vld_s & ~issue_s;

    // Saturating count of cycles a ready request was held back by fullness
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= '0;
        end else if (stall_s && (stall_cnt_r != '1)) begin
            stall_cnt_r <= stall_cnt_r + STALL_CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt_o = stall_cnt_r;
`endif

    fifo_wr_arb_chk #(.LVL_W(LVL_W)) u_chk (
        .clk      (clk),
        .rst      (rst),
        .rd_pop_i (rd_pop_i),
        .level_o  (level_r)
    );

endmodule
